// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the registered bitwise logic unit:
// operation-select width and the encoding of the eight bitwise ops.
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd6;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'd7;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise operator: selects one of eight ops on A and B.
module logic_op_comb
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    // The default arm keeps an unknown op from propagating X into the pipeline.
    case (op)
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_XOR:   result = A ^ B;
      OP_XNOR:  result = (A & B) | (~A & ~B);
      OP_NAND:  result = ~(A & B);
      OP_NOR:   result = ~(A | B);
      OP_PASSA: result = A;
      OP_NOTA:  result = ~A;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: one pipeline stage with valid/ready flow
// control, an operand-equality flag and a saturating count of equal pairs.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [OP_W-1:0]    op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   C,
  output logic               eq,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_cnt,
  output logic [COUNT_W-1:0] eq_cnt
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]   result;
  logic               a_eq_b;
  logic               accept;

  logic [WIDTH-1:0]   c_d, c_q;
  logic               eq_d, eq_q;
  logic               out_valid_d, out_valid_q;
  logic [COUNT_W-1:0] eq_cnt_d, eq_cnt_q;

  logic_op_comb #(
    .WIDTH (WIDTH)
  ) u_op (
    .A      (A),
    .B      (B),
    .op     (op),
    .result (result)
  );

  assign a_eq_b   = (A == B);
  // The stage is free when empty or when its current result leaves this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    c_d         = c_q;
    eq_d        = eq_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      c_d         = result;
      eq_d        = a_eq_b;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    eq_cnt_d = eq_cnt_q;
    if (clr_cnt) begin
      eq_cnt_d = '0;
    end else if (accept && a_eq_b && (eq_cnt_q != CNT_MAX)) begin
      eq_cnt_d = eq_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      eq_cnt_q    <= '0;
    end else begin
      c_q         <= c_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
      eq_cnt_q    <= eq_cnt_d;
    end
  end

  assign C         = c_q;
  assign eq        = eq_q;
  assign out_valid = out_valid_q;
  assign eq_cnt    = eq_cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit: successor to the single-bit combinational gates.
- Computes one of eight bitwise ops on two WIDTH-bit operands and holds the result in one pipeline stage with valid/ready flow control.
- Also produces an operand-equality flag and a saturating count of accepted equal pairs.
- Sits between operand producers and downstream datapath/checker logic.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 1).
- COUNT_W, 8, width of the equal-pair counter (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  operation select.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- C  output  WIDTH  registered result.
- eq  output  1  registered flag: A equalled B for the held result.
- out_valid  output  1  C and eq are valid.
- out_ready  input  1  consumer accepts C this cycle.
- clr_cnt  input  1  synchronous clear of eq_cnt.
- eq_cnt  output  COUNT_W  saturating count of accepted transfers with A==B.

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 PASS A, 7 NOT A. All ops are bitwise over WIDTH bits.
- XNOR bit i is (A[i]&B[i]) | (~A[i]&~B[i]).
- Reset (rst_n low, asynchronous): C = 0, eq = 0, out_valid = 0, eq_cnt = 0. Outputs hold these values while rst_n is low. Operation resumes on the first rising edge after deassertion.
- in_ready = !out_valid || out_ready. This is combinational and has no other dependency.
- Accept: in_valid && in_ready at a rising edge.
  - On that edge: C = op result, eq = (A==B), out_valid = 1.
  - Latency is 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no accept on the same edge. out_valid goes to 0; C and eq hold their last values.
- Simultaneous drain and accept: the new result replaces the old one, out_valid stays 1. Full throughput is one transfer per cycle.
- Stall: out_valid && !out_ready. C, eq and out_valid hold. in_ready = 0, and A, B and op are ignored.
- eq_cnt:
  - Increments by 1 on each accept with A==B.
  - Saturates at 2^COUNT_W-1 (no wrap).
  - clr_cnt has priority over increment: if both occur on the same edge, eq_cnt = 0.
- Any op value maps to a defined result; no X propagation from op.
- Reset mid-transfer: any held result is discarded and out_valid = 0 asynchronously.

Decomposition:
- Shared package holds:
  - op encoding constants: OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_PASSA, OP_NOTA;
  - the 3-bit op width constant.
- One sub-module, logic_op_comb: purely combinational. Inputs A, B, op; output result. The WIDTH parameter is passed down.
- The pipeline register, handshake and counter live in logic_unit_pipe.

Test Plan:
- Reset and truth table, WIDTH=8: hold rst_n=0 → C=0, out_valid=0, eq_cnt=0. Release, then with out_ready=1 send A=8'hF0, B=8'hCC for op 0..7 → C = C0, FC, 3C, C3, 3F, 03, F0, 0F, each one cycle after accept.
- Single-bit XNOR, WIDTH=1: op=3, apply (A,B) = (1,1), (0,1), (1,0), (0,0) → C = 1, 0, 0, 1; eq = 1, 0, 0, 1.
- Backpressure:
  - Accept A=8'h55, B=8'hAA, op=2 with out_ready=0 → C=FF, out_valid=1, in_ready=0.
  - Drive new operands for 3 cycles → C stays FF.
  - Raise out_ready with in_valid=1 → next result loads on the same edge; out_valid stays 1.
- Throughput: out_ready=1, in_valid=1 for 10 consecutive cycles → 10 results, out_valid continuously 1 after the first, in_ready continuously 1.
- Counter saturation, COUNT_W=2:
  - 5 accepts with A==B → eq_cnt = 1, 2, 3, 3, 3.
  - clr_cnt together with an equal accept → eq_cnt = 0.
  - Next equal accept → 1.
- Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and stalled → out_valid=0, C=0, eq_cnt=0 immediately, without waiting for a clock edge.
